seven_segment_driver: RTL and testbench

SEVEN_SEGMENT_DRIVER -- requirements
Module: seven_segment_driver

---
 rtl/seven_segment_driver.sv | 117 +++++++++++
 tb/tb_seven_segment_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_driver
//  Description : Time-multiplexed driver for a 4-digit common-anode seven
//                segment display showing MM:SS. A free-running refresh
//                counter selects one digit at a time. Anode and segment
//                outputs are both registered so they always change together.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_driver #(
   parameter int REFRESH_BITS = 18
) (
   input  logic       clock,
   input  logic       reset,          // synchronous, active-low
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   output logic [3:0] anode_signals,  // active-low digit enables
   output logic [6:0] display_out     // active-low segments a..g (bit6..bit0)
);

   localparam logic [6:0] c_SEG_OFF  = 7'b1111111;
   localparam logic [6:0] c_SEG_DASH = 7'b1111110;
   localparam logic [3:0] c_AN_OFF   = 4'b1111;
   localparam logic [5:0] c_MAX_VAL  = 6'd59;

   logic [REFRESH_BITS-1:0] r_counter;
   logic [1:0]              w_sel;

   logic [3:0] w_sec_ones;
   logic [3:0] w_sec_tens;
   logic [3:0] w_min_ones;
   logic [3:0] w_min_tens;
   logic       w_sec_oor;
   logic       w_min_oor;

   logic [3:0] w_digit;
   logic       w_dash;
   logic [3:0] w_anode;
   logic [6:0] w_seg;

   // Digit-to-segment lookup, active-low, bit order a..g.
   function automatic logic [6:0] f_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = c_SEG_DASH;
      endcase
      return seg;
   endfunction

   // The two MSBs of the refresh counter pick the digit being shown.
   assign w_sel = r_counter[REFRESH_BITS-1:REFRESH_BITS-2];

   // BCD split straight from the live inputs; no capture register, so a
   // change appears the next time its digit is scanned.
   assign w_sec_tens = 4'(seconds / 6'd10);
   assign w_sec_ones = 4'(seconds % 6'd10);
   assign w_min_tens = 4'(minutes / 6'd10);
   assign w_min_ones = 4'(minutes % 6'd10);
   assign w_sec_oor  = (seconds > c_MAX_VAL);
   assign w_min_oor  = (minutes > c_MAX_VAL);

   // Select the digit value, its anode, and whether the field is out of range.
   always_comb begin
      w_digit = w_sec_ones;
      w_dash  = w_sec_oor;
      w_anode = 4'b1110;
      case (w_sel)
         2'd0: begin
            w_digit = w_sec_ones;
            w_dash  = w_sec_oor;
            w_anode = 4'b1110;
         end
         2'd1: begin
            w_digit = w_sec_tens;
            w_dash  = w_sec_oor;
            w_anode = 4'b1101;
         end
         2'd2: begin
            w_digit = w_min_ones;
            w_dash  = w_min_oor;
            w_anode = 4'b1011;
         end
         default: begin
            w_digit = w_min_tens;
            w_dash  = w_min_oor;
            w_anode = 4'b0111;
         end
      endcase
      w_seg = w_dash ? c_SEG_DASH : f_encode(w_digit);
   end

   // Refresh counter plus output registers; anode and segments share one
   // register stage so they can never show mismatched digits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_counter     <= '0;
         anode_signals <= c_AN_OFF;
         display_out   <= c_SEG_OFF;
      end else begin
         r_counter     <= r_counter + 1'b1;
         anode_signals <= w_anode;
         display_out   <= w_seg;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_driver
//  Description : Scoreboard bench for seven_segment_driver with a 4-bit
//                refresh counter (4 cycles per digit). Stimulus pushes the
//                hand-computed expected outputs; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_driver;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [3:0] anode_signals;
   logic [6:0] display_out;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks;
   int    n_fails;
   int    ph;

   // Segment codes 0-9 from the display table.
   logic [6:0] seg_tab [10];
   logic [3:0] an_tab  [4];

   seven_segment_driver #(.REFRESH_BITS(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .minutes       (minutes),
      .seconds       (seconds),
      .anode_signals (anode_signals),
      .display_out   (display_out)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One reset cycle; outputs must be blanked, scan phase restarts.
   task automatic do_reset(input string tag);
      @(negedge clock);
      reset = 1'b0;
      exp_q.push_back('{an: 4'b1111, seg: 7'b1111111});
      tag_q.push_back(tag);
      ph = 0;
   endtask

   // Run n scan cycles; e0..e3 are the hand-computed segments for sel 0..3.
   task automatic run(input int n, input logic [5:0] m, input logic [5:0] s,
                      input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3,
                      input string tag);
      logic [6:0] e [4];
      int         sel;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         reset   = 1'b1;
         minutes = m;
         seconds = s;
         sel = (ph / 4) % 4;
         exp_q.push_back('{an: an_tab[sel], seg: e[sel]});
         tag_q.push_back($sformatf("%s sel%0d", tag, sel));
         ph++;
      end
   endtask

   // Monitor: after each rising edge, compare DUT outputs to the next entry.
   initial begin
      exp_t  e;
      string t;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (anode_signals !== e.an || display_out !== e.seg) begin
               n_fails++;
               $display("FAIL %s: got anode=%b seg=%b, expected anode=%b seg=%b",
                        t, anode_signals, display_out, e.an, e.seg);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
      $fatal(1, "timeout");
   end

   // Directed stimulus.
   initial begin
      n_checks = 0;
      n_fails  = 0;
      ph       = 0;
      reset    = 1'b0;
      minutes  = 6'd0;
      seconds  = 6'd0;
      seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
      seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
      seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
      seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
      seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
      an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
      an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

      // Reset held two cycles.
      do_reset("reset0");
      do_reset("reset1");

      // 12:34 for two full scans.
      run(32, 6'd12, 6'd34, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, "t1234");

      // Seconds 0-9 sweep, minutes 0; each value held one full scan.
      do_reset("reset_sweep");
      for (int s = 0; s < 10; s++)
         run(16, 6'd0, 6'(s), seg_tab[s], 7'b0000001, 7'b0000001, 7'b0000001,
             $sformatf("sweep%0d", s));

      // 59:59.
      run(16, 6'd59, 6'd59, 7'b0000100, 7'b0100100, 7'b0000100, 7'b0100100, "t5959");

      // Minutes out of range.
      run(16, 6'd63, 6'd59, 7'b0000100, 7'b0100100, 7'b1111110, 7'b1111110, "min63");

      // Seconds out of range (lower bound 60), minutes 7.
      run(16, 6'd7, 6'd60, 7'b1111110, 7'b1111110, 7'b0001111, 7'b0000001, "sec60");

      // Reset during sel 2, then scan restarts at seconds ones.
      do_reset("reset_pre");
      run(10, 6'd12, 6'd34, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, "pre_mid");
      do_reset("reset_mid");
      run(8, 6'd12, 6'd34, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, "post_mid");

      // Seconds 7 -> 8 while sel 3 is active; next sel 0 shows 8.
      do_reset("reset_chg");
      run(14, 6'd0, 6'd7, 7'b0001111, 7'b0000001, 7'b0000001, 7'b0000001, "chg7");
      run(6,  6'd0, 6'd8, 7'b0000000, 7'b0000001, 7'b0000001, 7'b0000001, "chg8");

      // Let the monitor drain.
      repeat (3) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
